// File: rtl/adder_arb_pkg.sv
// Shared constants, FSM state type and operand-slice helper for the shared-adder arbiter.
package adder_arb_pkg;
    localparam int DATA_W  = 32;
    localparam int MAX_REQ = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Callers zero-extend their packed operand bus to MAX_REQ lanes.
    function automatic logic [DATA_W-1:0] opnd_slice(input logic [MAX_REQ*DATA_W-1:0] v,
                                                     input int idx);
        return v[idx*DATA_W +: DATA_W];
    endfunction
endpackage

// File: rtl/adder32_rr_arbiter_fa32.sv
// 32-bit ripple-carry adder shared by all requesters of adder32_rr_arbiter.
module FullAdder_32
    import adder_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);
    logic [DATA_W:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[DATA_W];
endmodule

// File: rtl/adder32_rr_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);
    int unsigned k;
    logic        found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (en && !found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = ID_W'(k);
            end
        end
    end
endmodule

// File: rtl/adder32_rr_arbiter.sv
// Round-robin front end sharing one FullAdder_32 across NUM_REQ valid/ready requesters.
// Optional macro ADDER_ARB_SUB_EN adds per-requester req_sub (a - b, carry = not borrow).
module adder32_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_cin,
`ifdef ADDER_ARB_SUB_EN
    input  logic [NUM_REQ-1:0]        req_sub,
`endif
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_sum,
    output logic                      rsp_carry
);
    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, gnt_idx, op_id;
    logic [NUM_REQ-1:0]  gnt;
    logic [DATA_W-1:0]   op_a, op_b, add_b, add_sum;
    logic                op_cin, add_cin, add_cout, take;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (state_q == IDLE),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign take = (state_q == IDLE) && (|req_valid);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: if (take) begin
                req_ready = gnt;
                state_d   = ADD;
            end
            ADD:  state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

`ifdef ADDER_ARB_SUB_EN
    logic op_sub;
    // Subtract as a + ~b + 1; the requester's carry-in is ignored.
    assign add_b   = op_sub ? ~op_b : op_b;
    assign add_cin = op_sub | op_cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    op_sub <= 1'b0;
        else if (take) op_sub <= req_sub[gnt_idx];
    end
`else
    assign add_b   = op_b;
    assign add_cin = op_cin;
`endif

    FullAdder_32 u_add (
        .a    (op_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= ID_W'(NUM_REQ - 1);
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
        end else begin
            if (take) begin
                op_a   <= opnd_slice((MAX_REQ*DATA_W)'(req_a), int'(gnt_idx));
                op_b   <= opnd_slice((MAX_REQ*DATA_W)'(req_b), int'(gnt_idx));
                op_cin <= req_cin[gnt_idx];
                op_id  <= gnt_idx;
                ptr_q  <= gnt_idx;
            end
            if (state_q == ADD) begin
                rsp_sum   <= add_sum;
                rsp_carry <= add_cout;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end else if (state_q == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adder32_rr_arbiter.sv
// Self-checking bench for adder32_rr_arbiter: directed steps plus random traffic vs a transaction model.
module tb_adder32_rr_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_ready, req_cin;
    logic [N*32-1:0] req_a, req_b;
`ifdef ADDER_ARB_SUB_EN
    logic [N-1:0]    req_sub;
`endif
    logic            rsp_valid, rsp_ready, rsp_carry;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_sum;

    always #5 clk = ~clk;

    adder32_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADDER_ARB_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Requester-side stimulus.
    bit          v[N];
    logic [31:0] a[N], b[N];
    bit          ci[N], sb[N];

    // Transaction model: m_ph 0 = free, 1 = computing, 2 = response owed.
    int          m_ph, m_ptr, e_id, cyc;
    logic [31:0] e_sum;
    logic        e_carry;
    logic [N-1:0] last_acc;
    int          obs_g[$], obs_c[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int ptr, input bit vv[N]);
        for (int i = 1; i <= N; i++)
            if (vv[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom % 4)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = v[i];
            req_a[i*32 +: 32] = a[i];
            req_b[i*32 +: 32] = b[i];
            req_cin[i]        = ci[i];
`ifdef ADDER_ARB_SUB_EN
            req_sub[i]        = sb[i];
`endif
        end
    endtask

    // One clock: check outputs against the model, advance the model, cross the edge.
    task automatic tick();
        logic [N-1:0] er;
        logic [32:0]  full;
        int           g;
        drive();
        #1;
        er = '0;
        g  = -1;
        if (m_ph == 0) begin
            g = pick(m_ptr, v);
            if (g >= 0) er[g] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_ph == 2));
        if (m_ph == 2) begin
            chk("rsp_id", 64'(rsp_id), 64'(e_id));
            chk("rsp_sum", 64'(rsp_sum), 64'(e_sum));
            chk("rsp_carry", 64'(rsp_carry), 64'(e_carry));
        end
        for (int i = 0; i < N; i++)
            if (req_ready[i]) begin
                obs_g.push_back(i);
                obs_c.push_back(cyc);
            end
        last_acc = er;
        if (g >= 0) begin
            m_ptr = g;
            e_id  = g;
            if (sb[g]) begin
                e_sum   = a[g] - b[g];
                e_carry = (a[g] >= b[g]);
            end else begin
                full    = 33'(a[g]) + 33'(b[g]) + 33'(ci[g]);
                e_sum   = full[31:0];
                e_carry = full[32];
            end
            m_ph = 1;
        end else if (m_ph == 1) begin
            m_ph = 2;
        end else if (m_ph == 2 && rsp_ready) begin
            m_ph = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input bit chk_ready);
        rst_n = 1'b0;
        drive();
        #2;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
        chk("rst_rsp_carry", 64'(rsp_carry), 64'd0);
        if (chk_ready) chk("rst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ph  = 0;
        m_ptr = N - 1;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b0; a[i] = '0; b[i] = '0; ci[i] = 1'b0; sb[i] = 1'b0;
        end
    endtask

    // Single request from requester 0, then wait for its response and check constants.
    task automatic one_shot(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                            input bit xc, input bit xs, input logic [31:0] sum_x, input bit car_x);
        for (int k = 0; k < 6 && m_ph != 0; k++) tick();
        v[0] = 1'b1; a[0] = xa; b[0] = xb; ci[0] = xc; sb[0] = xs;
        tick();
        v[0] = 1'b0;
        tick();
        drive();
        #1;
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_sum"}, 64'(rsp_sum), 64'(sum_x));
        chk({tag, "_carry"}, 64'(rsp_carry), 64'(car_x));
        chk({tag, "_id"}, 64'(rsp_id), 64'd0);
        tick();
        sb[0] = 1'b0;
    endtask

    initial begin
        int base;
        m_ph = 0; m_ptr = N - 1; cyc = 0; e_id = 0; e_sum = '0; e_carry = 1'b0;
        rsp_ready = 1'b1;
        clear_reqs();
        drive();
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b1);

        // Basic add with latency check, then the all-ones wrap to carry.
        one_shot("t1", 32'd5, 32'd7, 1'b1, 1'b0, 32'd13, 1'b0);
        one_shot("t2", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Pointer at NUM_REQ-1 with requesters 0 and NUM_REQ-1 valid: 0 wins.
        clear_reqs();
        do_reset(1'b1);
        v[0] = 1'b1; v[N-1] = 1'b1; a[0] = 32'd9; a[N-1] = 32'd1;
        drive();
        #1;
        chk("wrap_grant", 64'(req_ready), 64'd1);
        repeat (4) begin
            tick();
            for (int i = 0; i < N; i++) if (last_acc[i]) v[i] = 1'b0;
        end

        // Reset while the add is in flight: response dropped, requester 0 first afterwards.
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; a[i] = rand_op(); b[i] = rand_op(); ci[i] = 1'($urandom);
        end
        for (int k = 0; k < 6 && m_ph != 1; k++) tick();
        chk("t5_in_add", 64'(m_ph), 64'd1);
        do_reset(1'b0);
        base = obs_g.size();

        // All valid continuously: strict rotation, one grant per 3 cycles.
        repeat (18) begin
            tick();
            for (int i = 0; i < N; i++)
                if (last_acc[i]) begin a[i] = rand_op(); b[i] = rand_op(); ci[i] = 1'($urandom); end
        end
        chk("t3_count", 64'(obs_g.size() >= base + 6), 64'd1);
        for (int k = 0; k < 6 && base + k < obs_g.size(); k++) begin
            chk("t3_order", 64'(obs_g[base+k]), 64'(k % N));
            if (k > 0) chk("t3_spacing", 64'(obs_c[base+k] - obs_c[base+k-1]), 64'd3);
        end

        // Back-pressure: hold the response for 10 cycles, then the next grant follows 1 cycle later.
        rsp_ready = 1'b0;
        for (int k = 0; k < 6 && m_ph != 2; k++) tick();
        chk("t4_in_resp", 64'(m_ph), 64'd2);
        repeat (10) tick();
        rsp_ready = 1'b1;
        tick();
        drive();
        #1;
        chk("t4_regrant", 64'(|req_ready), 64'd1);

`ifdef ADDER_ARB_SUB_EN
        clear_reqs();
        one_shot("t6a", 32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        one_shot("t6b", 32'd5, 32'd3, 1'b1, 1'b1, 32'd2, 1'b1);
`endif

        // Random traffic with withdrawals and random back-pressure.
        clear_reqs();
        repeat (400) begin
            rsp_ready = ($urandom % 10) < 7;
            tick();
            for (int i = 0; i < N; i++) begin
                if (last_acc[i] || (!v[i] && ($urandom % 4) == 0)) begin
                    v[i]  = last_acc[i] ? 1'($urandom) : 1'b1;
                    a[i]  = rand_op();
                    b[i]  = rand_op();
                    ci[i] = 1'($urandom);
`ifdef ADDER_ARB_SUB_EN
                    sb[i] = 1'($urandom);
`endif
                end else if (v[i] && ($urandom % 16) == 0) begin
                    v[i] = 1'b0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
